multi_channel_capture_mem: RTL and testbench

- Parametrised single-clock capture buffer for N parallel ADC channels, with one inferred bank of 2^ADDR_WIDTH x DATA_WIDTH per channel.
- Sits between the ADC front-end and the host readout path.
- Captures in single-shot or circular mode, then streams the stored samples out oldest-first over a valid/ready interface, channel-interleaved.

---
 rtl/multi_channel_capture_mem_if.sv | 40 ++++
 rtl/multi_channel_capture_mem.sv | 225 ++++++++++++++++++++++
 tb/tb_multi_channel_capture_mem.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_channel_capture_mem_if.sv
// Capture/readout bus for multi_channel_capture_mem.
// Groups control, sample input, readout stream and status.
interface multi_channel_capture_mem_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int N_CHANNELS = 2
);
    localparam int CH_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

    logic                           start;
    logic                           stop;
    logic                           mode;
    logic [ADDR_WIDTH:0]            capture_len;
    logic                           in_valid;
    logic [N_CHANNELS*DATA_WIDTH-1:0] in_data;
    logic                           rd_start;
    logic                           out_valid;
    logic                           out_ready;
    logic [DATA_WIDTH-1:0]          out_data;
    logic [CH_W-1:0]                out_channel;
    logic                           out_last;
    logic                           busy;
    logic                           done;
    logic                           wrapped;
    logic [ADDR_WIDTH:0]            sample_count;

    modport master (
        output start, stop, mode, capture_len,
        output in_valid, in_data, rd_start, out_ready,
        input  out_valid, out_data, out_channel, out_last,
        input  busy, done, wrapped, sample_count
    );

    modport slave (
        input  start, stop, mode, capture_len,
        input  in_valid, in_data, rd_start, out_ready,
        output out_valid, out_data, out_channel, out_last,
        output busy, done, wrapped, sample_count
    );
endinterface

// File: rtl/multi_channel_capture_mem.sv
// N-channel ADC capture buffer: single-shot/circular capture,
// oldest-first channel-interleaved readout over valid/ready.
module multi_channel_capture_mem #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int N_CHANNELS = 2
) (
    input  logic clk,
    input  logic rst_n,
    multi_channel_capture_mem_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CH_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam int LW    = ADDR_WIDTH + 1;
    localparam int DW    = DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE, S_CAPTURE, S_DONE, S_READOUT
    } state_e;

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [LW-1:0]         len_q, len_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]         count_q, count_d;
    logic                  wrapped_q, wrapped_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [CH_W-1:0]       iss_ch_q, iss_ch_d;
    logic [LW-1:0]         iss_cnt_q, iss_cnt_d;
    logic                  rdv_q, rdv_d;
    logic [CH_W-1:0]       rd_ch_q, rd_ch_d;
    logic                  rd_last_q, rd_last_d;
    logic                  skid_v_q, skid_v_d;
    logic [DW-1:0]         skid_data_q, skid_data_d;
    logic [CH_W-1:0]       skid_ch_q, skid_ch_d;
    logic                  skid_last_q, skid_last_d;

    logic [LW-1:0]         len_in;
    logic [LW-1:0]         wr_next;
    logic [LW-1:0]         rd_next;
    logic                  wr_en;
    logic                  issue;
    logic                  pop;
    logic                  cap_go;
    logic                  out_v;
    logic                  rd_consumed;
    logic                  rd_moved;
    logic [N_CHANNELS*DW-1:0] rd_bus;
    logic [DW-1:0]         rd_data;

    assign len_in = (bus.capture_len == '0 ||
                     bus.capture_len > LW'(DEPTH))
                  ? LW'(DEPTH) : bus.capture_len;
    assign wr_next = {1'b0, wr_ptr_q} + LW'(1);
    assign rd_next = {1'b0, rd_addr_q} + LW'(1);
    assign wr_en   = (state_q == S_CAPTURE) && bus.in_valid;
    assign cap_go  = bus.start &&
                     (state_q == S_IDLE || state_q == S_DONE);

    // Output stage: skid holds the older beat, rd register the newer one.
    assign out_v = rst_n && (skid_v_q || rdv_q);
    assign pop   = out_v && bus.out_ready;
    assign issue = (state_q == S_READOUT) && !bus.stop &&
                   (iss_cnt_q != count_q) &&
                   !(skid_v_q && rdv_q && !pop);
    assign rd_consumed = pop && rdv_q && !skid_v_q;
    assign rd_moved    = rdv_q && (skid_v_q ? pop : !pop);

    for (genvar k = 0; k < N_CHANNELS; k++) begin : g_bank
        logic [DW-1:0] mem_q [DEPTH];
        logic [DW-1:0] rdata_q;
        always_ff @(posedge clk) begin
            if (wr_en)
                mem_q[wr_ptr_q] <= bus.in_data[k*DW +: DW];
            if (issue)
                rdata_q <= mem_q[rd_addr_q];
        end
        assign rd_bus[k*DW +: DW] = rdata_q;
    end

    assign rd_data = rd_bus[int'(rd_ch_q)*DW +: DW];

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        len_d       = len_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        wrapped_d   = wrapped_q;
        rd_addr_d   = rd_addr_q;
        iss_ch_d    = iss_ch_q;
        iss_cnt_d   = iss_cnt_q;
        rdv_d       = rdv_q;
        rd_ch_d     = rd_ch_q;
        rd_last_d   = rd_last_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_ch_d   = skid_ch_q;
        skid_last_d = skid_last_q;

        unique case (state_q)
            S_IDLE: ;
            S_CAPTURE: begin
                if (wr_en) begin
                    wr_ptr_d = (wr_next == len_q)
                             ? '0 : wr_next[ADDR_WIDTH-1:0];
                    if (count_q != len_q)
                        count_d = count_q + LW'(1);
                    if (wr_next == len_q && mode_q)
                        wrapped_d = 1'b1;
                    if (wr_next == len_q && !mode_q)
                        state_d = S_DONE;
                end
                if (bus.stop)
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.rd_start) begin
                    state_d   = S_READOUT;
                    rd_addr_d = wrapped_q ? wr_ptr_q : '0;
                    iss_ch_d  = '0;
                    iss_cnt_d = '0;
                end
            end
            S_READOUT: begin
                if (bus.stop)
                    state_d = S_IDLE;
                else if (count_q == '0)
                    state_d = S_DONE;
                else if (pop && bus.out_last)
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (cap_go) begin
            state_d   = S_CAPTURE;
            mode_d    = bus.mode;
            len_d     = len_in;
            wr_ptr_d  = '0;
            count_d   = '0;
            wrapped_d = 1'b0;
        end

        if (issue) begin
            rd_ch_d   = iss_ch_q;
            rd_last_d = (iss_cnt_q + LW'(1) == count_q) &&
                        (iss_ch_q == CH_W'(N_CHANNELS - 1));
            if (iss_ch_q == CH_W'(N_CHANNELS - 1)) begin
                iss_ch_d  = '0;
                iss_cnt_d = iss_cnt_q + LW'(1);
                rd_addr_d = (rd_next == len_q)
                          ? '0 : rd_next[ADDR_WIDTH-1:0];
            end else begin
                iss_ch_d = iss_ch_q + CH_W'(1);
            end
        end

        if (rd_moved) begin
            skid_v_d    = 1'b1;
            skid_data_d = rd_data;
            skid_ch_d   = rd_ch_q;
            skid_last_d = rd_last_q;
        end else if (pop && skid_v_q) begin
            skid_v_d = 1'b0;
        end
        rdv_d = issue || (rdv_q && !rd_consumed && !rd_moved);

        if (state_d != S_READOUT) begin
            rdv_d    = 1'b0;
            skid_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            wrapped_q   <= 1'b0;
            rd_addr_q   <= '0;
            iss_ch_q    <= '0;
            iss_cnt_q   <= '0;
            rdv_q       <= 1'b0;
            rd_ch_q     <= '0;
            rd_last_q   <= 1'b0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_ch_q   <= '0;
            skid_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            wrapped_q   <= wrapped_d;
            rd_addr_q   <= rd_addr_d;
            iss_ch_q    <= iss_ch_d;
            iss_cnt_q   <= iss_cnt_d;
            rdv_q       <= rdv_d;
            rd_ch_q     <= rd_ch_d;
            rd_last_q   <= rd_last_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_ch_q   <= skid_ch_d;
            skid_last_q <= skid_last_d;
        end
    end

    assign bus.out_valid    = out_v;
    assign bus.out_data     = !out_v ? '0 :
                              skid_v_q ? skid_data_q : rd_data;
    assign bus.out_channel  = !out_v ? '0 :
                              skid_v_q ? skid_ch_q : rd_ch_q;
    assign bus.out_last     = out_v &&
                              (skid_v_q ? skid_last_q : rd_last_q);
    assign bus.busy         = rst_n && (state_q == S_CAPTURE ||
                                        state_q == S_READOUT);
    assign bus.done         = (state_q == S_DONE);
    assign bus.wrapped      = wrapped_q;
    assign bus.sample_count = count_q;
endmodule

// File: tb/tb_multi_channel_capture_mem.sv
// Scoreboard bench: directed captures on a 1024-deep and a 16-deep
// instance, readout beats checked by a monitor against a queue.
module tb_multi_channel_capture_mem;
    localparam int AW  = 10;
    localparam int AW2 = 4;
    localparam int DW  = 16;
    localparam int N   = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          ch;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          sel = 1'b0;
    logic          bp = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          mode = 1'b0;
    logic          in_valid = 1'b0;
    logic          rd_start = 1'b0;
    logic          out_ready = 1'b1;
    logic [AW:0]   len = '0;
    logic [N*DW-1:0] in_data = '0;

    multi_channel_capture_mem_if #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_CHANNELS(N)
    ) ia ();
    multi_channel_capture_mem_if #(
        .ADDR_WIDTH(AW2), .DATA_WIDTH(DW), .N_CHANNELS(N)
    ) ib ();

    assign ia.start       = start & ~sel;
    assign ia.stop        = stop & ~sel;
    assign ia.mode        = mode;
    assign ia.capture_len = len;
    assign ia.in_valid    = in_valid & ~sel;
    assign ia.in_data     = in_data;
    assign ia.rd_start    = rd_start & ~sel;
    assign ia.out_ready   = out_ready;
    assign ib.start       = start & sel;
    assign ib.stop        = stop & sel;
    assign ib.mode        = mode;
    assign ib.capture_len = len[AW2:0];
    assign ib.in_valid    = in_valid & sel;
    assign ib.in_data     = in_data;
    assign ib.rd_start    = rd_start & sel;
    assign ib.out_ready   = out_ready;

    multi_channel_capture_mem #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_CHANNELS(N)
    ) u_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    multi_channel_capture_mem #(
        .ADDR_WIDTH(AW2), .DATA_WIDTH(DW), .N_CHANNELS(N)
    ) u_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    logic          o_valid, o_ch, o_last;
    logic          o_busy, o_done, o_wrapped;
    logic [DW-1:0] o_data;
    logic [AW:0]   o_sc;
    assign o_valid   = sel ? ib.out_valid : ia.out_valid;
    assign o_ch      = sel ? ib.out_channel : ia.out_channel;
    assign o_last    = sel ? ib.out_last : ia.out_last;
    assign o_data    = sel ? ib.out_data : ia.out_data;
    assign o_busy    = sel ? ib.busy : ia.busy;
    assign o_done    = sel ? ib.done : ia.done;
    assign o_wrapped = sel ? ib.wrapped : ia.wrapped;
    assign o_sc      = sel ? {{(AW-AW2){1'b0}}, ib.sample_count}
                           : ia.sample_count;

    beat_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_pop = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Monitor: pops on every handshake, checks hold while stalled.
    logic          pv = 1'b0;
    logic          pr = 1'b1;
    logic [DW+2:0] prev_b = '0;
    initial forever begin
        beat_t e;
        logic [DW+2:0] cur;
        @(negedge clk);
        cur = {o_valid, o_data, o_ch, o_last};
        if (rst_n && pv && !pr)
            chk("stall hold", 32'(cur), 32'(prev_b));
        if (rst_n && o_valid && out_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL extra beat: got %0h want none",
                         o_data);
            end else begin
                e = q.pop_front();
                chk("beat data", 32'(o_data), 32'(e.d));
                chk("beat chan", 32'(o_ch), 32'(e.ch));
                chk("beat last", 32'(o_last), 32'(e.l));
                n_pop++;
            end
        end
        pv = rst_n && o_valid;
        pr = out_ready;
        prev_b = cur;
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic md, input int ln,
                           input int nb, input logic [15:0] b0,
                           input logic [15:0] b1, input bit stp);
        mode = md;
        len = (AW+1)'(ln);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < nb; i++) begin
            in_valid = 1'b1;
            in_data = {b1 + 16'(i), b0 + 16'(i)};
            stop = stp && (i == nb - 1);
            tick();
        end
        in_valid = 1'b0;
        stop = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] b0,
                            input logic [15:0] b1,
                            input int first, input int cnt);
        for (int i = first; i < first + cnt; i++) begin
            q.push_back('{d: b0 + 16'(i), ch: 1'b0, l: 1'b0});
            q.push_back('{d: b1 + 16'(i), ch: 1'b1,
                          l: (i == first + cnt - 1)});
        end
    endtask

    task automatic readout(input string nm);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk({nm, " lat t+1"}, 32'(o_valid), 0);
        tick();
        chk({nm, " lat t+2"}, 32'(o_valid), 1);
        for (int c = 0; c < 400; c++) begin
            if (o_done && q.size() == 0)
                break;
            tick();
        end
        chk({nm, " drained"}, q.size(), 0);
        chk({nm, " done"}, 32'(o_done), 1);
    endtask

    initial begin
        int p0;
        repeat (3) tick();
        chk("rst valid", 32'(o_valid), 0);
        chk("rst busy", 32'(o_busy), 0);
        chk("rst done", 32'(o_done), 0);
        chk("rst wrapped", 32'(o_wrapped), 0);
        chk("rst count", 32'(o_sc), 0);
        chk("rst data", 32'({o_data, o_ch, o_last}), 0);
        rst_n = 1'b1;
        tick();

        // single-shot len 4
        capture(1'b0, 4, 4, 16'h0010, 16'h0100, 1'b0);
        chk("ss done", 32'(o_done), 1);
        chk("ss count", 32'(o_sc), 4);
        chk("ss wrapped", 32'(o_wrapped), 0);
        push_exp(16'h0010, 16'h0100, 0, 4);
        readout("ss");

        // same data again under random backpressure
        bp = 1'b1;
        push_exp(16'h0010, 16'h0100, 0, 4);
        readout("bp");
        bp = 1'b0;
        tick();

        // circular len 4, 6 beats, then stop
        capture(1'b1, 4, 6, 16'h0010, 16'h0100, 1'b0);
        chk("circ busy", 32'(o_busy), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("circ done", 32'(o_done), 1);
        chk("circ wrapped", 32'(o_wrapped), 1);
        chk("circ count", 32'(o_sc), 4);
        push_exp(16'h0010, 16'h0100, 2, 4);
        readout("circ");

        // stop coincident with 3rd beat of an 8-deep capture
        capture(1'b0, 8, 3, 16'h0020, 16'h0200, 1'b1);
        chk("stop done", 32'(o_done), 1);
        chk("stop count", 32'(o_sc), 3);
        push_exp(16'h0020, 16'h0200, 0, 3);
        readout("stop");

        // reset while beat 3 is presented
        push_exp(16'h0020, 16'h0200, 0, 3);
        p0 = n_pop;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (n_pop >= p0 + 2)
                break;
            tick();
        end
        chk("rst beat3 up", 32'(o_valid), 1);
        chk("rst beat3 dat", 32'(o_data), 32'h0021);
        rst_n = 1'b0;
        #1;
        chk("rst mid valid", 32'(o_valid), 0);
        chk("rst mid busy", 32'(o_busy), 0);
        q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post rst done", 32'(o_done), 0);
        chk("post rst count", 32'(o_sc), 0);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        tick();
        chk("idle rd valid", 32'(o_valid), 0);
        chk("idle rd busy", 32'(o_busy), 0);

        // 16-deep instance, len 0 clamps to depth
        sel = 1'b1;
        tick();
        capture(1'b0, 0, 16, 16'h0040, 16'h0400, 1'b0);
        chk("clamp done", 32'(o_done), 1);
        chk("clamp count", 32'(o_sc), 16);
        for (int i = 16; i < 20; i++) begin
            in_valid = 1'b1;
            in_data = {16'h0400 + 16'(i), 16'h0040 + 16'(i)};
            tick();
        end
        in_valid = 1'b0;
        chk("clamp count2", 32'(o_sc), 16);
        chk("clamp wrapped", 32'(o_wrapped), 0);
        push_exp(16'h0040, 16'h0400, 0, 16);
        readout("clamp");

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
